// File: rtl/ws2812_pkg.sv
// Shared register map, bit positions and sequencer state encoding for the WS2812 APB chain driver.
package ws2812_pkg;

  // Byte offsets; only PADDR[11:2] takes part in decoding.
  localparam logic [11:0] REG_CTRL       = 12'h000;
  localparam logic [11:0] REG_STATUS     = 12'h004;
  localparam logic [11:0] REG_COUNT      = 12'h008;
  localparam logic [11:0] REG_PIXEL_BASE = 12'h100;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/ws2812_bit_serialiser.sv
// Emits one 24-bit GRB word MSB first with cycle-exact high/low timing per bit.
// word_done is high during the final cycle of bit 0, so a load in that cycle chains words without a gap.
module ws2812_bit_serialiser #(
  parameter int T_BIT = 125,
  parameter int T1H   = 80,
  parameter int T0H   = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] word,
  output logic        led,
  output logic        word_done
);

  localparam int PH_W = $clog2(T_BIT);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(T_BIT - 1);
  localparam logic [PH_W-1:0] T1H_P   = PH_W'(T1H);
  localparam logic [PH_W-1:0] T0H_P   = PH_W'(T0H);

  logic [23:0]     shreg;
  logic [4:0]      bit_idx;
  logic [PH_W-1:0] phase;
  logic            active;
  logic            hi_now;

  always_comb begin
    hi_now = 1'b0;
    if (active)
      hi_now = shreg[bit_idx] ? (phase < T1H_P) : (phase < T0H_P);
  end

  assign word_done = active && (phase == LAST_PH) && (bit_idx == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led     <= 1'b0;
      active  <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      phase   <= '0;
    end else begin
      led <= hi_now;
      if (load) begin
        shreg   <= word;
        bit_idx <= 5'd23;
        phase   <= '0;
        active  <= 1'b1;
      end else if (active) begin
        if (phase == LAST_PH) begin
          phase <= '0;
          if (bit_idx == 5'd0)
            active <= 1'b0;
          else
            bit_idx <= bit_idx - 5'd1;
        end else begin
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ws2812_apb_chain.sv
// APB3 slave holding a GRB pixel memory and sequencing frames plus latch period onto a WS2812 string.
// Optional frame-done interrupt logic is built only when WS2812_IRQ_EN is defined.
module ws2812_apb_chain
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int T_BIT    = 125,
  parameter int T1H      = 80,
  parameter int T0H      = 40,
  parameter int T_RES    = 8000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        LED,
  output logic        IRQ
);

  localparam int CNT_W = $clog2(NUM_LEDS + 1);
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int RES_W = (T_RES > 1) ? $clog2(T_RES) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_LEDS);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(T_RES - 1);

  state_t           state;
  logic [CNT_W-1:0] count_q, frame_len, pix_idx, next_idx;
  logic [RES_W-1:0] res_cnt;
  logic             done_q, irq_en_q;
  logic [23:0]      pix_mem [NUM_LEDS];

  // Zero-wait APB3: a transfer completes in the cycle where PSEL & PENABLE are high (PREADY tied 1).
  logic       access, wr, busy;
  logic [9:0] word_addr, pix_off;
  logic       is_ctrl, is_status, is_count, is_pix, mapped;
  logic [IDX_W-1:0] pix_sel;
  logic       go, pix_we, w1c_done, more, ser_load, word_done;
  logic [23:0] ser_word;
  logic       unused_addr;

  assign access    = PSEL & PENABLE;
  assign wr        = access & PWRITE;
  assign busy      = (state != ST_IDLE);
  assign word_addr = PADDR[11:2];
  assign pix_off   = word_addr - REG_PIXEL_BASE[11:2];
  assign pix_sel   = pix_off[IDX_W-1:0];
  assign is_ctrl   = (word_addr == REG_CTRL[11:2]);
  assign is_status = (word_addr == REG_STATUS[11:2]);
  assign is_count  = (word_addr == REG_COUNT[11:2]);
  assign is_pix    = (word_addr >= REG_PIXEL_BASE[11:2]) && ({1'b0, pix_off} < 11'(NUM_LEDS));
  assign mapped    = is_ctrl | is_status | is_count | is_pix;
  assign unused_addr = ^{PADDR[31:12], PADDR[1:0]};

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~mapped | (PWRITE & is_pix & busy));

  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      if (is_ctrl)        PRDATA = {30'd0, irq_en_q, 1'b0};
      else if (is_status) PRDATA = {30'd0, done_q, busy};
      else if (is_count)  PRDATA = 32'(count_q);
      else if (is_pix)    PRDATA = {8'd0, pix_mem[pix_sel]};
    end
  end

  assign go       = wr & is_ctrl & PWDATA[CTRL_GO] & (state == ST_IDLE) & (count_q != '0);
  assign pix_we   = wr & is_pix & ~busy;
  assign w1c_done = wr & is_status & PWDATA[STATUS_DONE];
  assign more     = (pix_idx != frame_len - CNT_W'(1));
  assign next_idx = pix_idx + CNT_W'(1);
  assign ser_load = go | ((state == ST_SEND) & word_done & more);
  assign ser_word = go ? pix_mem[0] : pix_mem[next_idx[IDX_W-1:0]];

  ws2812_bit_serialiser #(
    .T_BIT (T_BIT),
    .T1H   (T1H),
    .T0H   (T0H)
  ) u_ser (
    .clk       (PCLK),
    .rst       (PRESET),
    .load      (ser_load),
    .word      (ser_word),
    .led       (LED),
    .word_done (word_done)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_LEDS; i++) pix_mem[i] <= '0;
    end else if (pix_we) begin
      pix_mem[pix_sel] <= PWDATA[23:0];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      count_q   <= MAX_CNT;
      frame_len <= '0;
      pix_idx   <= '0;
      res_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      if (wr & is_count)
        count_q <= (PWDATA > 32'(NUM_LEDS)) ? MAX_CNT : PWDATA[CNT_W-1:0];
      // A latch period ending in the same cycle as a DONE clear leaves DONE set.
      if (state == ST_LATCH && res_cnt == RES_LAST)
        done_q <= 1'b1;
      else if (w1c_done)
        done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_SEND;
            pix_idx   <= '0;
            frame_len <= count_q;
          end
        end
        ST_SEND: begin
          if (word_done) begin
            if (more) begin
              pix_idx <= next_idx;
            end else begin
              state   <= ST_LATCH;
              res_cnt <= '0;
            end
          end
        end
        ST_LATCH: begin
          if (res_cnt == RES_LAST) state <= ST_IDLE;
          else                     res_cnt <= res_cnt + RES_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WS2812_IRQ_EN
  logic irq_q;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr & is_ctrl) irq_en_q <= PWDATA[CTRL_IRQ_EN];
      irq_q <= done_q & irq_en_q;
    end
  end
  assign IRQ = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign IRQ      = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_apb_chain.sv
// Directed bench for ws2812_apb_chain: register map, bit waveform, frame timing, error responses, IRQ and reset.
module tb_ws2812_apb_chain;

  localparam int NUM_LEDS = 8;
  localparam int T_BIT    = 125;
  localparam int T1H      = 80;
  localparam int T0H      = 40;
  localparam int T_RES    = 8000;
  localparam int NT       = 24 * T_BIT;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, LED, IRQ;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned go_cyc;
  logic [31:0] rd;
  logic        err;
  logic [31:0] exp_q[$];

  ws2812_apb_chain #(
    .NUM_LEDS (NUM_LEDS), .T_BIT (T_BIT), .T1H (T1H), .T0H (T0H), .T_RES (T_RES)
  ) dut (
    .PCLK (PCLK), .PRESET (PRESET), .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
    .PADDR (PADDR), .PWDATA (PWDATA), .PRDATA (PRDATA), .PREADY (PREADY),
    .PSLVERR (PSLVERR), .LED (LED), .IRQ (IRQ)
  );

  // Clock / cycle counter
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: setup after edge n+1, access sampled after edge n+2, transfer ends at edge n+3.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic slverr);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 slverr = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic slverr);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 begin data = PRDATA; slverr = PSLVERR; end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) begin
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    logic [23:0] w;
    int shape_err, hi_cnt, thr, low_err;

    repeat (3) @(posedge PCLK);
    #1;
    check("rst_led", LED, 0);
    check("rst_irq", IRQ, 0);
    PRESET = 1'b0;

    // Reset state of every register
    apb_read(32'h000, rd, err); check("rst_ctrl", rd, 32'h0);
    apb_read(32'h004, rd, err); check("rst_status", rd, 32'h0);
    apb_read(32'h008, rd, err); check("rst_count", rd, 32'd8);
    for (int i = 0; i < NUM_LEDS; i++) begin
      apb_read(32'h100 + 4 * i, rd, err);
      check($sformatf("rst_pix%0d", i), rd, 32'h0);
    end

    // Single-pixel frame, waveform checked bit by bit
    apb_write(32'h100, 32'hFF80_0001, err); check("pix0_wr_err", err, 0);
    apb_read(32'h100, rd, err); check("pix0_rd", rd, 32'h0080_0001);
    apb_write(32'h008, 32'd1, err);
    apb_write(32'h000, 32'h1, err);
    go_cyc = cyc;
    w = 24'h800001;
    for (int k = 0; k < 24; k++) exp_q.push_back(w[23 - k] ? T1H : T0H);
    shape_err = 0;
    for (int k = 0; k < 24; k++) begin
      thr = w[23 - k] ? T1H : T0H;
      hi_cnt = 0;
      for (int p = 0; p < T_BIT; p++) begin
        @(posedge PCLK); #1;
        if (LED === 1'b1) hi_cnt++;
        if (LED !== ((p < thr) ? 1'b1 : 1'b0)) shape_err++;
      end
      check($sformatf("bit%0d_high", k), hi_cnt, exp_q.pop_front());
    end
    check("led_shape", shape_err, 0);
    low_err = 0;
    for (int i = 0; i < T_RES - 10; i++) begin
      @(posedge PCLK); #1;
      if (LED !== 1'b0) low_err++;
    end
    check("latch_low", low_err, 0);
    wait_until(go_cyc + NT + T_RES - 1 - 2);
    apb_read(32'h004, rd, err); check("f1_busy_last", rd, 32'h1);
    apb_read(32'h004, rd, err); check("f1_done", rd, 32'h2);
    apb_write(32'h004, 32'h2, err);
    apb_read(32'h004, rd, err); check("done_w1c", rd, 32'h0);

    // Three-pixel frame with illegal/ignored accesses mid-frame
    apb_write(32'h104, 32'h0012_3456, err);
    apb_write(32'h108, 32'h0000_FF00, err);
    apb_write(32'h008, 32'd3, err);
    apb_write(32'h000, 32'h1, err);
    go_cyc = cyc;
    apb_write(32'h104, 32'h00AB_CDEF, err); check("busy_pix_wr_err", err, 1);
    apb_read(32'h104, rd, err); check("busy_pix_rd", rd, 32'h0012_3456);
    check("busy_pix_rd_err", err, 0);
    apb_write(32'h000, 32'h1, err); check("busy_go_err", err, 0);
    apb_write(32'h008, 32'd2, err);
    apb_read(32'h008, rd, err); check("count_mid", rd, 32'd2);
    wait_until(go_cyc + 1 + 24 * T_BIT + 60);  check("p1_b23", LED, 0);
    wait_until(go_cyc + 1 + 27 * T_BIT + 60);  check("p1_b20", LED, 1);
    wait_until(go_cyc + 1 + 55 * T_BIT + 60);  check("p2_b16", LED, 0);
    wait_until(go_cyc + 1 + 56 * T_BIT + 60);  check("p2_b15", LED, 1);
    wait_until(go_cyc + 15000 - 2);
    apb_read(32'h004, rd, err); check("f3_still_busy", rd, 32'h1);
    wait_until(go_cyc + 3 * NT + T_RES - 2);
    apb_read(32'h004, rd, err); check("f3_end", rd, 32'h2);

    // Map boundaries, COUNT clamp, zero-length GO
    apb_write(32'h120, 32'h1, err); check("unmapped_wr_err", err, 1);
    apb_read(32'h120, rd, err); check("unmapped_rd", rd, 32'h0);
    check("unmapped_rd_err", err, 1);
    apb_read(32'h11C, rd, err); check("pix7_err", err, 0);
    apb_write(32'h008, 32'd20, err);
    apb_read(32'h008, rd, err); check("count_clamp", rd, 32'd8);
    apb_write(32'h008, 32'd0, err);
    apb_write(32'h000, 32'h1, err);
    apb_read(32'h004, rd, err); check("go_count0", rd, 32'h2);

    // Frame-done interrupt
    apb_write(32'h004, 32'h2, err);
    apb_write(32'h000, 32'h2, err);
    apb_read(32'h000, rd, err);
`ifdef WS2812_IRQ_EN
    check("ctrl_irq_en", rd, 32'h2);
`else
    check("ctrl_irq_en", rd, 32'h0);
`endif
    apb_write(32'h008, 32'd1, err);
    apb_write(32'h000, 32'h3, err);
    go_cyc = cyc;
`ifdef WS2812_IRQ_EN
    wait_until(go_cyc + NT + T_RES);
    check("irq_before", IRQ, 0);
    wait_until(go_cyc + NT + T_RES + 1);
    check("irq_set", IRQ, 1);
    apb_write(32'h004, 32'h2, err);
    check("irq_hold", IRQ, 1);
`else
    wait_until(go_cyc + NT + T_RES + 1);
    check("irq_tied", IRQ, 0);
    apb_write(32'h004, 32'h2, err);
`endif
    @(posedge PCLK); #1;
    check("irq_clear", IRQ, 0);

    // Asynchronous reset mid-frame
    apb_write(32'h000, 32'h1, err);
    go_cyc = cyc;
    wait_until(go_cyc + 50);
    check("pre_rst_led", LED, 1);
    PRESET = 1'b1;
    #1 check("rst_led_async", LED, 0);
    #20;
    PRESET = 1'b0;
    apb_read(32'h004, rd, err); check("post_rst_status", rd, 32'h0);
    apb_read(32'h100, rd, err); check("post_rst_pix0", rd, 32'h0);
    apb_read(32'h104, rd, err); check("post_rst_pix1", rd, 32'h0);
    apb_read(32'h008, rd, err); check("post_rst_count", rd, 32'd8);
    repeat (5) @(posedge PCLK);
    #1 check("post_rst_led", LED, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
